seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
//  - Latches a display word through a ready/load handshake.
//  - Steps one digit at a time, with a blanking guard between digits to prevent ghosting.
//  - Decodes each digit's nibble to active-low segments.
//  - Sits between datapath result registers and the board display pins.

---
 rtl/seg_scan_pkg.sv | 45 ++++
 rtl/seg_scan_timer.sv | 69 ++++++
 rtl/seg_scan_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared definitions for the 7-segment scan controller.
//   scan_state_e : two-slot scan FSM encoding (GUARD blanking slot, SHOW lit slot)
//   SEG_BLANK    : active-low segment pattern with every segment off
//   seg7_code()  : hex nibble -> active-low a..g pattern ([6]=a .. [0]=g)
//   seg_idx_w()  : digit index width, never narrower than 1 bit
//   seg_div_w()  : slot divider width, sized for the longer of the two slots
package seg_scan_pkg;

   typedef enum logic {
      ST_GUARD = 1'b0,
      ST_SHOW  = 1'b1
   } scan_state_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Decimal digits only; 10..15 render blank so stray codes never light garbage.
   function automatic logic [6:0] seg7_code(input logic [3:0] nibble);
      logic [6:0] code;
      case (nibble)
         4'd0:    code = 7'h01;
         4'd1:    code = 7'h4F;
         4'd2:    code = 7'h12;
         4'd3:    code = 7'h06;
         4'd4:    code = 7'h4C;
         4'd5:    code = 7'h24;
         4'd6:    code = 7'h20;
         4'd7:    code = 7'h0F;
         4'd8:    code = 7'h00;
         4'd9:    code = 7'h04;
         default: code = SEG_BLANK;
      endcase
      return code;
   endfunction

   function automatic int seg_idx_w(input int num_digits);
      return (num_digits > 1) ? $clog2(num_digits) : 1;
   endfunction

   function automatic int seg_div_w(input int refresh_div, input int guard_cyc);
      int longest;
      longest = (refresh_div > guard_cyc) ? refresh_div : guard_cyc;
      return $clog2(longest);
   endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot timer for the scan controller: counts cycles inside the current slot
// and tracks which digit is being scanned.
//   clk_i      : system clock, rising edge
//   rst_ni     : asynchronous active-low reset
//   state_i    : current FSM slot (GUARD or SHOW), selects the slot length
//   slot_end_o : 1 on the last cycle of the current slot
//   wrap_o     : 1 on the last SHOW cycle of the last digit (frame boundary)
//   idx_o      : digit currently guarded/shown; advances when SHOW ends
module seg_scan_timer
   import seg_scan_pkg::*;
#(
   parameter  int NUM_DIGITS  = 4,
   parameter  int REFRESH_DIV = 100000,
   parameter  int GUARD_CYC   = 4,
   localparam int IDX_W       = seg_idx_w(NUM_DIGITS)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  scan_state_e       state_i,
   output logic              slot_end_o,
   output logic              wrap_o,
   output logic [IDX_W-1:0]  idx_o
);

   localparam int DIV_W = seg_div_w(REFRESH_DIV, GUARD_CYC);

   logic [DIV_W-1:0] div_q, div_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             slot_end;
   logic             last_digit;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      slot_end   = 1'b0;
      last_digit = (idx_q == IDX_W'(NUM_DIGITS - 1));
      if (state_i == ST_GUARD) begin
         slot_end = (div_q == DIV_W'(GUARD_CYC - 1));
      end else begin
         slot_end = (div_q == DIV_W'(REFRESH_DIV - 1));
      end

      // The FSM changes state exactly when the slot ends, so clearing here
      // restarts the divider on every state change.
      div_d = slot_end ? '0 : div_q + 1'b1;

      idx_d = idx_q;
      if (slot_end && (state_i == ST_SHOW)) begin
         idx_d = last_digit ? '0 : idx_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_q <= '0;
         idx_q <= '0;
      end else begin
         div_q <= div_d;
         idx_q <= idx_d;
      end
   end

   assign slot_end_o = slot_end;
   assign wrap_o     = slot_end && (state_i == ST_SHOW) && last_digit;
   assign idx_o      = idx_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment
// display. A display word is taken through a ready/load handshake, staged,
// and committed only at a frame boundary so a frame never mixes two words.
// Each digit is preceded by an all-anodes-off guard slot to avoid ghosting.
//   Clk         : system clock, rising edge
//   Rst_n       : asynchronous active-low reset
//   load        : request to take value_in / dp_in / digit_en_in
//   ready       : 1 = a load in this cycle is accepted
//   value_in    : digit k nibble at [4k+3:4k], digit 0 rightmost
//   dp_in       : per-digit decimal point request
//   digit_en_in : per-digit enable; a disabled digit keeps its anode off
//   an          : active-low anode selects
//   seg         : active-low segments, [6]=a .. [0]=g
//   dp          : active-low decimal point
//   frame_done  : one-cycle pulse in the first guard cycle after each frame wrap
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int GUARD_CYC   = 4
) (
   input  logic                    Clk,
   input  logic                    Rst_n,
   input  logic                    load,
   output logic                    ready,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en_in,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame_done
);

   localparam int IDX_W = seg_idx_w(NUM_DIGITS);

   scan_state_e      state_q;
   logic             slot_end;
   logic             wrap;
   logic [IDX_W-1:0] idx;

   seg_scan_timer #(
      .NUM_DIGITS  (NUM_DIGITS),
      .REFRESH_DIV (REFRESH_DIV),
      .GUARD_CYC   (GUARD_CYC)
   ) u_timer (
      .clk_i      (Clk),
      .rst_ni     (Rst_n),
      .state_i    (state_q),
      .slot_end_o (slot_end),
      .wrap_o     (wrap),
      .idx_o      (idx)
   );

   // ---------------------------------------------------------------- handshake
   logic [4*NUM_DIGITS-1:0] stg_val_q, stg_val_d, act_val_q, act_val_d;
   logic [NUM_DIGITS-1:0]   stg_dp_q,  stg_dp_d,  act_dp_q,  act_dp_d;
   logic [NUM_DIGITS-1:0]   stg_en_q,  stg_en_d,  act_en_q,  act_en_d;
   logic                    ready_q,   ready_d;
   logic                    accept;

   assign accept = load && ready_q;

   // ready low means a staged word is waiting for the next wrap.
   always_comb begin
      stg_val_d = stg_val_q;
      stg_dp_d  = stg_dp_q;
      stg_en_d  = stg_en_q;
      act_val_d = act_val_q;
      act_dp_d  = act_dp_q;
      act_en_d  = act_en_q;
      ready_d   = ready_q;
      if (accept) begin
         if (wrap) begin
            // Accepted on the boundary itself: nothing to wait for.
            act_val_d = value_in;
            act_dp_d  = dp_in;
            act_en_d  = digit_en_in;
         end else begin
            stg_val_d = value_in;
            stg_dp_d  = dp_in;
            stg_en_d  = digit_en_in;
            ready_d   = 1'b0;
         end
      end else if (wrap && !ready_q) begin
         act_val_d = stg_val_q;
         act_dp_d  = stg_dp_q;
         act_en_d  = stg_en_q;
         ready_d   = 1'b1;
      end
   end

   // NOTE: the word registers are reset, not left as uninitialised storage:
   // a zero enable mask is what keeps the display dark after reset and what
   // discards a pending word when reset hits mid-frame.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         stg_val_q <= '0;
         stg_dp_q  <= '0;
         stg_en_q  <= '0;
         act_val_q <= '0;
         act_dp_q  <= '0;
         act_en_q  <= '0;
         ready_q   <= 1'b1;
      end else begin
         stg_val_q <= stg_val_d;
         stg_dp_q  <= stg_dp_d;
         stg_en_q  <= stg_en_d;
         act_val_q <= act_val_d;
         act_dp_q  <= act_dp_d;
         act_en_q  <= act_en_d;
         ready_q   <= ready_d;
      end
   end

   // ------------------------------------------------------ digit about to show
   // During GUARD, idx already names the next digit, so its pattern is ready
   // to be registered on the edge that enters SHOW.
   logic [NUM_DIGITS-1:0] show_an;
   logic [6:0]            show_seg;
   logic                  show_dp;
   logic [3:0]            nibble;
   logic                  digit_on;
   logic                  dp_req;

   always_comb begin
      nibble   = '0;
      digit_on = 1'b0;
      dp_req   = 1'b0;
      show_an  = '1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx == IDX_W'(k)) begin
            nibble     = act_val_q[4*k +: 4];
            digit_on   = act_en_q[k];
            dp_req     = act_dp_q[k];
            show_an[k] = ~act_en_q[k];
         end
      end
      // A disabled digit drives blank segments so its slot looks exactly
      // like a guard slot on the pins.
      show_seg = digit_on ? seg7_code(nibble) : SEG_BLANK;
      show_dp  = ~(dp_req & digit_on);
   end

   // ------------------------------------------------------ FSM + output regs
   logic [NUM_DIGITS-1:0] an_q;
   logic [6:0]            seg_q;
   logic                  dp_q;
   logic                  frame_done_q;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q      <= ST_GUARD;
         an_q         <= '1;
         seg_q        <= SEG_BLANK;
         dp_q         <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= wrap;
         if (slot_end) begin
            if (state_q == ST_GUARD) begin
               state_q <= ST_SHOW;
               an_q    <= show_an;
               seg_q   <= show_seg;
               dp_q    <= show_dp;
            end else begin
               state_q <= ST_GUARD;
               an_q    <= '1;
               seg_q   <= SEG_BLANK;
               dp_q    <= 1'b1;
            end
         end
      end
   end

   assign ready      = ready_q;
   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, 8-cycle show, 2-cycle guard).
// The reference model works from the frame schedule: every output is a function
// of the cycle count since reset release and of the word currently committed.
module tb_seg_scan_ctrl;

   localparam int ND   = 4;
   localparam int RD   = 8;
   localparam int GC   = 2;
   localparam int SLOT = GC + RD;
   localparam int P    = ND * SLOT;

   localparam logic [6:0] SEG_TAB [16] = '{
      7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
      7'h00, 7'h04, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
   };

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load;
   logic        ready;
   logic [15:0] value_in;
   logic [3:0]  dp_in;
   logic [3:0]  digit_en_in;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   always #5 clk = ~clk;

   seg_scan_ctrl #(
      .NUM_DIGITS  (ND),
      .REFRESH_DIV (RD),
      .GUARD_CYC   (GC)
   ) dut (
      .Clk         (clk),
      .Rst_n       (rst_n),
      .load        (load),
      .ready       (ready),
      .value_in    (value_in),
      .dp_in       (dp_in),
      .digit_en_in (digit_en_in),
      .an          (an),
      .seg         (seg),
      .dp          (dp),
      .frame_done  (frame_done)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   int          n_edge;
   int          last_fd;
   logic [15:0] m_act_val, m_stg_val;
   logic [3:0]  m_act_dp, m_stg_dp, m_act_en, m_stg_en;
   bit          m_pending;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s @edge %0d: got %0h expected %0h", tag, n_edge, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      n_edge    = 0;
      last_fd   = -1;
      m_act_val = '0;
      m_stg_val = '0;
      m_act_dp  = '0;
      m_stg_dp  = '0;
      m_act_en  = '0;
      m_stg_en  = '0;
      m_pending = 1'b0;
   endtask

   // One rising edge: handshake and commit rules.
   task automatic model_edge();
      bit at_wrap;
      n_edge++;
      at_wrap = (n_edge % P == 0);
      if (load && !m_pending) begin
         if (at_wrap) begin
            m_act_val = value_in;
            m_act_dp  = dp_in;
            m_act_en  = digit_en_in;
         end else begin
            m_stg_val = value_in;
            m_stg_dp  = dp_in;
            m_stg_en  = digit_en_in;
            m_pending = 1'b1;
         end
      end else if (at_wrap && m_pending) begin
         m_act_val = m_stg_val;
         m_act_dp  = m_stg_dp;
         m_act_en  = m_stg_en;
         m_pending = 1'b0;
      end
   endtask

   task automatic compare_all();
      int         pos, k, off;
      logic [3:0] nib;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      pos   = n_edge % P;
      k     = pos / SLOT;
      off   = pos % SLOT;
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      if (off >= GC && m_act_en[2'(k)]) begin
         nib           = 4'(m_act_val >> (4 * k));
         e_an[2'(k)]   = 1'b0;
         e_seg         = SEG_TAB[nib];
         e_dp          = ~m_act_dp[2'(k)];
      end
      check("an",         32'(an),         32'(e_an));
      check("seg",        32'(seg),        32'(e_seg));
      check("dp",         32'(dp),         32'(e_dp));
      check("ready",      32'(ready),      32'(!m_pending));
      check("frame_done", 32'(frame_done), 32'(n_edge > 0 && pos == 0));
      if (frame_done === 1'b1) begin
         if (last_fd >= 0) check("frame_gap", 32'(n_edge - last_fd), 32'(P));
         last_fd = n_edge;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic load_word(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
      value_in    = v;
      dp_in       = d;
      digit_en_in = e;
      load        = 1'b1;
      step();
      load        = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      load        = 1'b0;
      value_in    = '0;
      dp_in       = '0;
      digit_en_in = '0;
      model_reset();
      repeat (3) @(negedge clk);
      compare_all();
      rst_n = 1'b1;
      compare_all();

      // Idle after reset: display stays dark, ready stays high.
      repeat (200) step();

      // First word, loaded mid-frame: waits for the wrap, then 1234.
      load_word(16'h1234, 4'h0, 4'hF);
      repeat (2 * P) step();

      // Disabled digit, decimal point, non-decimal nibble.
      load_word(16'hA000, 4'b0010, 4'b1110);
      repeat (2 * P) step();

      // Second load while a word is pending is ignored.
      while (n_edge % P != 1) step();
      load_word(16'h1234, 4'h0, 4'hF);
      value_in = 16'h9999;
      load     = 1'b1;
      repeat (5) step();
      load = 1'b0;
      for (int i = 0; i < 2 * P && m_pending; i++) step();
      // Load landing on the wrap cycle goes straight to the next frame.
      while ((n_edge + 1) % P != 0) step();
      load_word(16'h5678, 4'b0101, 4'hF);
      repeat (2 * P) step();

      // Reset mid-SHOW of digit 2 with a word pending.
      while (n_edge % P != 3) step();
      load_word(16'h8421, 4'hF, 4'hF);
      while (n_edge % P != 2 * SLOT + GC + 3) step();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
      compare_all();
      repeat (2 * P) step();

      // Random traffic; frame timing must stay fixed regardless of loads.
      repeat (800) begin
         load        = ($urandom_range(0, 3) == 0);
         value_in    = 16'($urandom);
         dp_in       = 4'($urandom);
         digit_en_in = 4'($urandom);
         step();
      end
      load = 1'b0;
      repeat (P) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
